// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 configuration sequencer:
// the ROM marker words and the sequencer state encoding.
package ov7670_cfg_pkg;

    // ROM word that terminates the register table
    localparam logic [15:0] CFG_END   = 16'hFFFF;

    // ROM word that inserts the post-reset settling delay
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        DELAY,
        FLUSH,
        DONE
    } cfg_state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// Fixed-length wait timer. Cleared before use, then counts while enabled;
// `expired` flags the last cycle of a DELAY_CYCLES-long enabled window.
// Shared with the SCCB power-up wait, so it carries no sequencer knowledge.
module cfg_delay_timer #(
    parameter int DELAY_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_CYCLES - 1);

    logic [CW-1:0] count;

    // Count enabled cycles from zero, parking on the terminal value
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 init ROM from address 0, turning each {reg, value}
// word into one SCCB write command. FFF0 inserts a settling delay and
// FFFF ends the table; the table also ends after entry 255.
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int DELAY_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        sccb_idle,
    output logic        busy,
    output logic        done
);

    localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;

    cfg_state_t state;
    logic       delay_clear;
    logic       delay_en;
    logic       delay_expired;

    // The timer restarts while a word is decoded and runs only in DELAY
    assign delay_clear = (state == DECODE);
    assign delay_en    = (state == DELAY);

    cfg_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_delay_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (delay_clear),
        .en     (delay_en),
        .expired(delay_expired)
    );

    // Sequencer FSM; rom_addr doubles as the table address counter so every
    // output comes straight from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_reg   <= 8'd0;
            cmd_data  <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= 8'd0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    if (rom_data == CFG_END) begin
                        state <= FLUSH;
                    end else if (rom_data == CFG_DELAY) begin
                        state <= DELAY;
                    end else begin
                        cmd_reg   <= rom_data[15:8];
                        cmd_data  <= rom_data[7:0];
                        cmd_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (rom_addr == 8'hFF) begin
                            state <= FLUSH;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end
                DELAY: begin
                    if (delay_expired) begin
                        if (rom_addr == 8'hFF) begin
                            state <= FLUSH;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end
                FLUSH: begin
                    if (sccb_idle) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= 8'd0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
